alu_seq: RTL and testbench

Parametrised, registered successor to the combinational ALU. Accepts one operation per valid/ready handshake and returns a registered result plus status flags.
- Keeps the existing 3-bit op codes.
- Fixes arithmetic shift right to true sign extension.
- Adds OR, SHL and an iterative multiply.
- Sits between the register-file read stage and writeback; holds its result under output backpressure.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_mul_iter.sv | 42 ++++
 rtl/alu_seq.sv | 100 ++++++++++
 tb/tb_alu_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state type shared by the sequential ALU
package alu_pkg;
  localparam logic [3:0] OP_NOT = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_ASR = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle, WIDTH steps
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic run;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mc;
  logic [WIDTH-1:0] mp;
  // product is the accumulator after the current step, so it is final on the cycle done is high
  assign product = acc + (mp[0] ? mc : '0);
  assign done = run & (cnt == LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mc  <= {{WIDTH{1'b0}}, a};
      mp  <= b;
    end else if (run) begin
      run <= ~done;
      cnt <= cnt + 1'b1;
      acc <= product;
      mc  <= mc << 1;
      mp  <= mp >> 1;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, flags and iterative multiply
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);
  state_t state, nxt;
  logic acc, is_mul, mul_done, load, sat, ac, av, ae, c, v, e;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] ar, r;
  logic signed [WIDTH-1:0] asr;
  assign acc = in_valid & in_ready;
  assign is_mul = op == OP_MUL;
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = state == DONE;
  assign sat = |b[WIDTH-1:SHW];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign asr = $signed(a) >>> b[SHW-1:0];
  always_comb begin
    ar = '0;
    ac = 1'b0;
    av = 1'b0;
    ae = 1'b0;
    case (op)
      OP_NOT: ar = ~a;
      OP_AND: ar = a & b;
      OP_ASR: ar = sat ? {WIDTH{a[WIDTH-1]}} : asr;
      OP_XOR: ar = a ^ b;
      OP_ADD: begin
        ar = sum[WIDTH-1:0];
        ac = sum[WIDTH];
        av = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ar = dif[WIDTH-1:0];
        ac = dif[WIDTH];
        av = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  ar = a | b;
      OP_SHL: ar = sat ? '0 : a << b[SHW-1:0];
      OP_MUL: ar = '0;
      default: ae = 1'b1;
    endcase
  end
  // in BUSY the only thing that can load the output registers is the multiplier finishing
  assign r = state == BUSY ? prod[WIDTH-1:0] : ar;
  assign c = state == BUSY ? |prod[2*WIDTH-1:WIDTH] : ac;
  assign v = state == BUSY ? c | prod[WIDTH-1] : av;
  assign e = (state != BUSY) & ae;
  assign load = (acc & ~is_mul) | ((state == BUSY) & mul_done);
  always_comb
    nxt = acc ? (is_mul ? BUSY : DONE) :
          state == BUSY ? (mul_done ? DONE : BUSY) :
          (state == DONE) & ~out_ready ? DONE : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else if (load) begin
      result <= r;
      carry  <= c;
      ovf    <= v;
      zero   <= ~e & ~|r;
      neg    <= r[WIDTH-1];
      err    <= e;
    end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(acc & is_mul),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(prod)
  );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at WIDTH=32
module tb_alu_seq;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, carry, ovf, zero, neg, err;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] op = '0;
  int n = 0, nf = 0, cyc;
  logic bad;
  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    n++;
    assert (o === x) else begin
      nf++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    @(negedge clk);
    a = x;
    b = y;
    op = o;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out();
    cyc = 1;
    bad = 1'b0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      if (!out_valid && in_ready) bad = 1'b1;
    end
  endtask
  function automatic logic [4:0] flags();
    return {carry, ovf, zero, neg, err};
  endfunction
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset.ctl", {out_valid, in_ready}, 2'b01);
    chk("reset.res", {result, flags()}, {32'h0, 5'b00000});
    @(negedge clk) rst = 1'b0;
    a = 32'hFFFFFFFF;
    b = 32'h1;
    op = 4'h4;
    in_valid = 1'b1;
    #1 chk("add.pre", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("add.res", {out_valid, result, flags()}, {1'b1, 32'h0, 5'b10100});
    @(posedge clk);
    #1 chk("add.hold", {out_valid, in_ready, result}, {2'b10, 32'h0});
    issue(32'd5, 32'd7, 4'h5);
    chk("sub.res", {out_valid, result, flags()}, {1'b1, 32'hFFFFFFFE, 5'b10010});
    chk("sub.ready", in_ready, 1'b1);
    issue(32'h80000000, 32'd4, 4'h2);
    chk("asr4", {out_valid, result, flags()}, {1'b1, 32'hF8000000, 5'b00010});
    issue(32'h80000000, 32'd40, 4'h2);
    chk("asr40", {out_valid, result, flags()}, {1'b1, 32'hFFFFFFFF, 5'b00010});
    issue(32'h0, 32'h0, 4'h0);
    chk("not", {result, flags()}, {32'hFFFFFFFF, 5'b00010});
    issue(32'h000000F0, 32'h00000F00, 4'h6);
    chk("or", {result, flags()}, {32'h00000FF0, 5'b00000});
    issue(32'h1, 32'd31, 4'h7);
    chk("shl31", {result, flags()}, {32'h80000000, 5'b00010});
    issue(32'h1, 32'd32, 4'h7);
    chk("shl32", {result, flags()}, {32'h0, 5'b00100});
    issue(32'h7FFFFFFF, 32'h1, 4'h4);
    chk("add.ovf", {result, flags()}, {32'h80000000, 5'b01010});
    issue(32'h80000000, 32'h1, 4'h5);
    chk("sub.ovf", {result, flags()}, {32'h7FFFFFFF, 5'b01000});
    issue(32'hFF00FF00, 32'h0FF00FF0, 4'h1);
    chk("and", {result, flags()}, {32'h0F000F00, 5'b00000});
    @(posedge clk);
    #1 chk("idle", {out_valid, in_ready}, 2'b01);
    issue(32'h12345, 32'h100, 4'h8);
    chk("mul.busy0", {out_valid, in_ready}, 2'b00);
    wait_out();
    chk("mul.lat", cyc, 33);
    chk("mul.busy", bad, 1'b0);
    chk("mul.res", {result, flags()}, {32'h01234500, 5'b00000});
    issue(32'h80000000, 32'h2, 4'h8);
    wait_out();
    chk("mulovf.lat", cyc, 33);
    chk("mulovf.res", {result, flags()}, {32'h0, 5'b11100});
    issue(32'hF0F0F0F0, 32'hFF00FF00, 4'h3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'h1;
    b = 32'h1;
    op = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("bp.hold", {out_valid, in_ready, result, flags()}, {2'b10, 32'h0FF00FF0, 5'b00000});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp.release", {out_valid, in_ready, result}, {2'b01, 32'h0FF00FF0});
    issue(32'd3, 32'd5, 4'h8);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst.mul", {out_valid, in_ready, result, flags()}, {2'b01, 32'h0, 5'b00000});
    @(negedge clk) rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) bad = 1'b1;
    end
    chk("rst.nooutput", bad, 1'b0);
    issue(32'd2, 32'd3, 4'h4);
    chk("add5", {out_valid, result, flags()}, {1'b1, 32'd5, 5'b00000});
    issue(32'd5, 32'd3, 4'hA);
    chk("illegal", {out_valid, result, flags()}, {1'b1, 32'h0, 5'b00001});
    @(posedge clk);
    #1 chk("final.idle", {out_valid, in_ready}, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, nf);
    $finish;
  end
endmodule
